// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// data_types : shared types and constants for the instruction fetch slice.
//   word32_t      - 32-bit machine word (addresses and instruction data)
//   fetch_state_t - fetch FSM encoding
//   INSTR_BYTES   - byte stride between consecutive instruction words
//   align_word    - clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package data_types;

    typedef logic [31:0] word32_t;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DROP  = 3'd4
    } fetch_state_t;

    localparam word32_t INSTR_BYTES = 32'd4;

    function automatic word32_t align_word(input word32_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if : instruction-memory read port plus downstream instruction
// queue push port, seen from the fetch unit.
//   imem_req_o / imem_addr_o / imem_ready_i        - request handshake
//   imem_resp_valid_i / imem_rdata_i               - one response per request
//   iq_write_o / iq_data_o / iq_full_i / iq_flush_o - queue push and clear
// master : fetch unit side.  slave : memory/queue (environment) side.
// -----------------------------------------------------------------------------
interface fetch_unit_if;
    import data_types::*;

    logic    imem_req_o;
    word32_t imem_addr_o;
    logic    imem_ready_i;
    logic    imem_resp_valid_i;
    word32_t imem_rdata_i;
    logic    iq_write_o;
    word32_t iq_data_o;
    logic    iq_full_i;
    logic    iq_flush_o;

    modport master (
        output imem_req_o, imem_addr_o, iq_write_o, iq_data_o, iq_flush_o,
        input  imem_ready_i, imem_resp_valid_i, imem_rdata_i, iq_full_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, iq_write_o, iq_data_o, iq_flush_o,
        output imem_ready_i, imem_resp_valid_i, imem_rdata_i, iq_full_i
    );

endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit : sequential instruction fetcher with at most one memory read
// outstanding. Returned words are pushed into a downstream queue in the same
// cycle they arrive, or parked in a hold register while the queue is full.
// A redirect flushes the queue, re-points the pc and discards any in-flight
// or parked word.
//
// Ports
//   clk_i         - system clock, rising edge
//   reset_i       - asynchronous active-high reset
//   bus           - fetch_unit_if.master (memory + queue signals)
//   redirect_i    - control-flow redirect request
//   redirect_pc_i - redirect target (byte offset bits ignored)
//
// Outputs are decoded from the registered state so that an asynchronous reset
// (state forced to BOOT) drops every output without waiting for a clock, and
// so a response can be pushed with zero latency.
// -----------------------------------------------------------------------------
module fetch_unit
    import data_types::*;
#(
    parameter word32_t RESET_PC = 32'h0000_0000
) (
    input  logic          clk_i,
    input  logic          reset_i,
    fetch_unit_if.master  bus,
    input  logic          redirect_i,
    input  word32_t       redirect_pc_i
);

    fetch_state_t state_q, state_d;
    word32_t      pc_q,    pc_d;
    word32_t      hold_q,  hold_d;

    logic push_wait;
    logic push_hold;

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    always_comb begin
        // A redirect suppresses any push in the same cycle; pushes also never
        // happen while the queue reports full.
        push_wait = (state_q == ST_WAIT) && bus.imem_resp_valid_i &&
                    !bus.iq_full_i && !redirect_i;
        push_hold = (state_q == ST_HOLD) && !bus.iq_full_i && !redirect_i;

        bus.imem_req_o  = (state_q == ST_FETCH);
        bus.imem_addr_o = (state_q == ST_FETCH) ? pc_q : '0;
        bus.iq_write_o  = push_wait || push_hold;

        if (push_wait)
            bus.iq_data_o = bus.imem_rdata_i;
        else if (state_q == ST_HOLD)
            bus.iq_data_o = hold_q;
        else
            bus.iq_data_o = '0;

        // Keep the flush quiet while reset is held so all outputs read 0.
        bus.iq_flush_o = redirect_i && !reset_i;
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hold_d  = hold_q;

        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
                if (redirect_i)
                    pc_d = align_word(redirect_pc_i);
            end

            ST_FETCH: begin
                // Redirect wins over the post-accept increment; an accepted
                // request still owes a response, which DROP swallows.
                if (redirect_i) begin
                    pc_d    = align_word(redirect_pc_i);
                    state_d = bus.imem_ready_i ? ST_DROP : ST_FETCH;
                end else if (bus.imem_ready_i) begin
                    pc_d    = pc_q + INSTR_BYTES;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (redirect_i) begin
                    pc_d    = align_word(redirect_pc_i);
                    state_d = bus.imem_resp_valid_i ? ST_FETCH : ST_DROP;
                end else if (bus.imem_resp_valid_i) begin
                    if (bus.iq_full_i) begin
                        hold_d  = bus.imem_rdata_i;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end

            ST_HOLD: begin
                if (redirect_i) begin
                    pc_d    = align_word(redirect_pc_i);
                    state_d = ST_FETCH;
                end else if (!bus.iq_full_i) begin
                    state_d = ST_FETCH;
                end
            end

            ST_DROP: begin
                if (redirect_i)
                    pc_d = align_word(redirect_pc_i);
                if (bus.imem_resp_valid_i)
                    state_d = ST_FETCH;
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_BOOT;
            pc_q    <= align_word(RESET_PC);
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import data_types::*;

    logic    clk = 1'b0;
    logic    rst;
    logic    redirect;
    word32_t redirect_pc;
    int      checks   = 0;
    int      failures = 0;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk_i         (clk),
        .reset_i       (rst),
        .bus           (bus),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.imem_ready_i      = 1'b0;
        bus.imem_resp_valid_i = 1'b0;
        bus.imem_rdata_i      = '0;
        bus.iq_full_i         = 1'b0;
        redirect              = 1'b0;
        redirect_pc           = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h5555_5555;
        #3;
        checks++; if (bus.imem_req_o !== 1'b0) begin failures++; $display("FAIL rst_req: got %b want 0", bus.imem_req_o); end
        checks++; if (bus.imem_addr_o !== 32'h0) begin failures++; $display("FAIL rst_addr: got %h want 0", bus.imem_addr_o); end
        checks++; if (bus.iq_flush_o !== 1'b0) begin failures++; $display("FAIL rst_flush: got %b want 0", bus.iq_flush_o); end
        redirect = 1'b0;
        step(); step();
        @(negedge clk);
        checks++; if ({bus.iq_write_o, bus.iq_data_o} !== 33'h0) begin failures++; $display("FAIL rst_iq: got %b/%h want 0/0", bus.iq_write_o, bus.iq_data_o); end
        step();
        rst = 1'b0;
        // First cycle after release is BOOT: everything still quiet.
        @(negedge clk);
        checks++; if ({bus.imem_req_o, bus.imem_addr_o} !== 33'h0) begin failures++; $display("FAIL boot_out: got %b/%h want 0/0", bus.imem_req_o, bus.imem_addr_o); end
        step();
    endtask

    // Three fetches, each answered one cycle after acceptance.
    task automatic test_sequential();
        word32_t exp_addr;
        word32_t word;
        for (int i = 0; i < 3; i++) begin
            exp_addr = 32'h100 + 32'(i * 4);
            word     = 32'hA000_0000 + 32'(i);
            bus.imem_ready_i = 1'b1;
            @(negedge clk);
            checks++; if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, exp_addr}) begin failures++; $display("FAIL seq_addr%0d: got %b/%h want 1/%h", i, bus.imem_req_o, bus.imem_addr_o, exp_addr); end
            step();
            bus.imem_ready_i = 1'b0;
            bus.imem_resp_valid_i = 1'b1;
            bus.imem_rdata_i = word;
            @(negedge clk);
            checks++; if ({bus.imem_req_o, bus.iq_write_o, bus.iq_data_o} !== {2'b01, word}) begin failures++; $display("FAIL seq_push%0d: got %b%b/%h want 01/%h", i, bus.imem_req_o, bus.iq_write_o, bus.iq_data_o, word); end
            step();
            bus.imem_resp_valid_i = 1'b0;
            bus.imem_rdata_i = '0;
        end
    endtask

    // Response arrives while the queue is full for three cycles.
    task automatic test_hold();
        bus.imem_ready_i = 1'b1;
        @(negedge clk);
        checks++; if (bus.imem_addr_o !== 32'h10C) begin failures++; $display("FAIL hold_addr: got %h want 0000010c", bus.imem_addr_o); end
        step();
        bus.imem_ready_i = 1'b0;
        bus.imem_resp_valid_i = 1'b1;
        bus.imem_rdata_i = 32'hDEAD_BEEF;
        bus.iq_full_i = 1'b1;
        @(negedge clk);
        checks++; if (bus.iq_write_o !== 1'b0) begin failures++; $display("FAIL hold_nopush_w: got %b want 0", bus.iq_write_o); end
        step();
        bus.imem_resp_valid_i = 1'b0;
        bus.imem_rdata_i = 32'h0BAD_0BAD;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if ({bus.iq_write_o, bus.imem_req_o, bus.iq_data_o} !== {2'b00, 32'hDEAD_BEEF}) begin failures++; $display("FAIL hold_wait%0d: got %b%b/%h want 00/deadbeef", i, bus.iq_write_o, bus.imem_req_o, bus.iq_data_o); end
            step();
        end
        bus.iq_full_i = 1'b0;
        @(negedge clk);
        checks++; if ({bus.iq_write_o, bus.iq_data_o} !== {1'b1, 32'hDEAD_BEEF}) begin failures++; $display("FAIL hold_push: got %b/%h want 1/deadbeef", bus.iq_write_o, bus.iq_data_o); end
        step();
        @(negedge clk);
        checks++; if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, 32'h110}) begin failures++; $display("FAIL hold_next: got %b/%h want 1/00000110", bus.imem_req_o, bus.imem_addr_o); end
    endtask

    // Redirect while waiting, response shows up two cycles later.
    task automatic test_redirect_wait();
        bus.imem_ready_i = 1'b1;
        step();
        bus.imem_ready_i = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h0000_2003;
        @(negedge clk);
        checks++; if ({bus.iq_flush_o, bus.iq_write_o} !== 2'b10) begin failures++; $display("FAIL rw_flush: got %b%b want 10", bus.iq_flush_o, bus.iq_write_o); end
        step();
        redirect = 1'b0;
        @(negedge clk);
        checks++; if ({bus.imem_req_o, bus.iq_flush_o} !== 2'b00) begin failures++; $display("FAIL rw_drop: got %b%b want 00", bus.imem_req_o, bus.iq_flush_o); end
        step();
        bus.imem_resp_valid_i = 1'b1;
        bus.imem_rdata_i = 32'h1234_5678;
        @(negedge clk);
        checks++; if ({bus.iq_write_o, bus.imem_req_o} !== 2'b00) begin failures++; $display("FAIL rw_discard: got %b%b want 00", bus.iq_write_o, bus.imem_req_o); end
        step();
        bus.imem_resp_valid_i = 1'b0;
        @(negedge clk);
        checks++; if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, 32'h2000}) begin failures++; $display("FAIL rw_target: got %b/%h want 1/00002000", bus.imem_req_o, bus.imem_addr_o); end
    endtask

    // Redirect coincides with the response in WAIT.
    task automatic test_redirect_resp();
        bus.imem_ready_i = 1'b1;
        step();
        bus.imem_ready_i = 1'b0;
        bus.imem_resp_valid_i = 1'b1;
        bus.imem_rdata_i = 32'hCAFE_F00D;
        redirect = 1'b1;
        redirect_pc = 32'h0000_3000;
        @(negedge clk);
        checks++; if ({bus.iq_write_o, bus.iq_flush_o} !== 2'b01) begin failures++; $display("FAIL rr_nopush: got %b%b want 01", bus.iq_write_o, bus.iq_flush_o); end
        step();
        clear_inputs();
        @(negedge clk);
        checks++; if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, 32'h3000}) begin failures++; $display("FAIL rr_target: got %b/%h want 1/00003000", bus.imem_req_o, bus.imem_addr_o); end
    endtask

    // Redirect with no acceptance keeps fetching; then pc wraps at 2^32.
    task automatic test_wrap();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        @(negedge clk);
        checks++; if ({bus.imem_req_o, bus.iq_flush_o} !== 2'b11) begin failures++; $display("FAIL wr_flush: got %b%b want 11", bus.imem_req_o, bus.iq_flush_o); end
        step();
        redirect = 1'b0;
        bus.imem_ready_i = 1'b1;
        @(negedge clk);
        checks++; if (bus.imem_addr_o !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wr_top: got %h want fffffffc", bus.imem_addr_o); end
        step();
        bus.imem_ready_i = 1'b0;
        bus.imem_resp_valid_i = 1'b1;
        bus.imem_rdata_i = 32'h0000_0013;
        step();
        bus.imem_resp_valid_i = 1'b0;
        @(negedge clk);
        checks++; if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, 32'h0}) begin failures++; $display("FAIL wr_wrap: got %b/%h want 1/00000000", bus.imem_req_o, bus.imem_addr_o); end
    endtask

    // Accepted request plus redirect: increment overridden, response dropped.
    task automatic test_redirect_accept();
        bus.imem_ready_i = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_4000;
        step();
        clear_inputs();
        @(negedge clk);
        checks++; if (bus.imem_req_o !== 1'b0) begin failures++; $display("FAIL ra_drop: got %b want 0", bus.imem_req_o); end
        step();
        bus.imem_resp_valid_i = 1'b1;
        bus.imem_rdata_i = 32'h7777_7777;
        @(negedge clk);
        checks++; if (bus.iq_write_o !== 1'b0) begin failures++; $display("FAIL ra_discard: got %b want 0", bus.iq_write_o); end
        step();
        bus.imem_resp_valid_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.imem_addr_o !== 32'h4000) begin failures++; $display("FAIL ra_target: got %h want 00004000", bus.imem_addr_o); end
        // Stray response in FETCH must be ignored.
        step();
        bus.imem_resp_valid_i = 1'b1;
        @(negedge clk);
        checks++; if ({bus.iq_write_o, bus.imem_req_o, bus.imem_addr_o} !== {2'b01, 32'h4000}) begin failures++; $display("FAIL ra_stray: got %b%b/%h want 01/00004000", bus.iq_write_o, bus.imem_req_o, bus.imem_addr_o); end
        step();
        bus.imem_resp_valid_i = 1'b0;
    endtask

    // Asynchronous reset while a response is being pushed in WAIT.
    task automatic test_async_reset();
        bus.imem_ready_i = 1'b1;
        step();
        bus.imem_ready_i = 1'b0;
        bus.imem_resp_valid_i = 1'b1;
        bus.imem_rdata_i = 32'h5A5A_5A5A;
        #1;
        checks++; if (bus.iq_write_o !== 1'b1) begin failures++; $display("FAIL ar_pre: got %b want 1", bus.iq_write_o); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if ({bus.imem_req_o, bus.iq_write_o, bus.iq_data_o} !== 34'h0) begin failures++; $display("FAIL ar_drop: got %b%b/%h want 00/0", bus.imem_req_o, bus.iq_write_o, bus.iq_data_o); end
        step();
        clear_inputs();
        rst = 1'b0;
        step();
        @(negedge clk);
        checks++; if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, 32'h100}) begin failures++; $display("FAIL ar_restart: got %b/%h want 1/00000100", bus.imem_req_o, bus.imem_addr_o); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_hold();
        test_redirect_wait();
        test_redirect_resp();
        test_wrap();
        test_redirect_accept();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk_i  input  1  single system clock; all state on rising edge.
REQ-003 reset_i  input  1  asynchronous, active-high reset.
REQ-004 imem_req_o  output  1  instruction-memory read request valid.
REQ-005 imem_addr_o  output  word32_t  request byte address, bits [1:0] always 0.
REQ-006 imem_ready_i  input  1  memory accepts request this cycle when high with imem_req_o.
REQ-007 imem_resp_valid_i  input  1  read data valid, exactly one per accepted request, any later cycle.
REQ-008 imem_rdata_i  input  word32_t  returned instruction word.
REQ-009 iq_write_o  output  1  push into downstream instruction queue.
REQ-010 iq_data_o  output  word32_t  word pushed into the queue.
REQ-011 iq_full_i  input  1  downstream queue full; no push while high.
REQ-012 iq_flush_o  output  1  single-cycle synchronous clear of downstream queue.
REQ-013 redirect_i  input  1  control-flow redirect request.
REQ-014 redirect_pc_i  input  word32_t  redirect target address.

Function
REQ-015 FSM states SHALL be BOOT, FETCH, WAIT, HOLD, DROP; at most one memory request outstanding.
REQ-016 BOOT: all outputs 0; unconditionally to FETCH next clock.
REQ-017 FETCH: imem_req_o=1, imem_addr_o=pc; on imem_ready_i, pc<=pc+4 and go to WAIT.
REQ-018 WAIT: on imem_resp_valid_i with iq_full_i=0, iq_write_o=1, iq_data_o=imem_rdata_i same cycle (zero latency), go to FETCH.
REQ-019 WAIT: on imem_resp_valid_i with iq_full_i=1, capture imem_rdata_i into hold register, go to HOLD.
REQ-020 HOLD: iq_data_o=hold register; when iq_full_i=0, iq_write_o=1 and go to FETCH; else remain.
REQ-021 DROP: imem_req_o=0, iq_write_o=0; on imem_resp_valid_i discard data, go to FETCH.
REQ-022 imem_req_o SHALL be 1 only in FETCH; iq_write_o SHALL never be 1 while iq_full_i=1.
REQ-023 PC arithmetic 32-bit modulo: 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-024 redirect_i (any state except BOOT): pc<={redirect_pc_i[31:2],2'b00}, iq_flush_o=1 same cycle, iq_write_o=0 that cycle.
REQ-025 Redirect next state: FETCH with request accepted that cycle -> DROP; FETCH not accepted -> FETCH (new pc next cycle); WAIT without response -> DROP; WAIT with response -> FETCH (response discarded); HOLD -> FETCH (hold discarded); DROP -> DROP unless response this cycle, then FETCH.
REQ-026 Redirect in BOOT SHALL update pc and still go to FETCH; iq_flush_o=1.
REQ-027 Accepted-request pc increment SHALL be overridden by a simultaneous redirect.
REQ-028 imem_resp_valid_i in FETCH, HOLD or BOOT is a protocol error and SHALL be ignored.

Reset
REQ-029 reset_i asserted SHALL immediately force state=BOOT, pc=RESET_PC, hold register=0, regardless of clock.
REQ-030 During and directly after reset all outputs SHALL be 0 (imem_addr_o=0, iq_data_o=0).
REQ-031 Reset mid-request SHALL abandon the outstanding request; the environment guarantees no stale response after reset.

Structure
REQ-032 fetch_state_t enum and INSTR_BYTES=4 constant SHALL live in package data_types alongside word32_t.
REQ-033 Single module, no sub-modules; downstream queue instantiated by the parent, iq_flush_o wired to its reset.

Verification
REQ-034 Reset release, RESET_PC=32'h100, ready=1, response 1 cycle later -> addresses 0x100,0x104,0x108 fetched; words pushed in order.
REQ-035 Response 32'hDEAD_BEEF while iq_full_i=1 for 3 cycles -> HOLD, no push; push of DEADBEEF in first cycle full drops, then next fetch.
REQ-036 Redirect to 32'h2003 while WAIT, response 2 cycles later -> flush pulse, response discarded, next imem_addr_o=0x2000.
REQ-037 pc=32'hFFFF_FFFC fetched -> next imem_addr_o=32'h0000_0000.
REQ-038 Redirect same cycle as imem_resp_valid_i in WAIT -> no push, FETCH at redirect target next cycle.
REQ-039 reset_i asserted asynchronously mid-WAIT -> imem_req_o, iq_write_o drop before next edge; restart at RESET_PC.
